// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter that serialises load/store and
// loader/debug requests onto a single fixed-latency data memory interface.
// Each accepted request gets exactly one rsp_valid pulse on its own port.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    // Counter covers latencies 1..15; it is loaded with MEM_LATENCY-1.
    localparam int unsigned   CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic                winner_q,     winner_d;
    logic                write_q,      write_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [1:0]          rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]   rdata_q,      rdata_d;
    logic                rd_en_q,      rd_en_d;
    logic                wr_en_q,      wr_en_d;

    logic                winner_c;
    logic                grant_c;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        winner_c = 1'b0;
        case (req_valid)
            2'b01:   winner_c = 1'b0;
            2'b10:   winner_c = 1'b1;
            2'b11:   winner_c = ~last_grant_q;
            default: winner_c = 1'b0;
        endcase
    end

    // Acceptance is purely a function of state and req_valid (no memory path).
    assign grant_c   = (state_q == ST_IDLE) && (req_valid != 2'b00);
    assign req_ready = grant_c ? (winner_c ? 2'b10 : 2'b01) : 2'b00;

    // Next-state and datapath update for the IDLE -> BUSY -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 2'b00;
        rdata_d      = rdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    winner_d     = winner_c;
                    last_grant_d = winner_c;
                    write_d      = req_write[winner_c];
                    addr_d       = winner_c ? req_addr1  : req_addr0;
                    wdata_d      = winner_c ? req_wdata1 : req_wdata0;
                    cnt_d        = CNT_LOAD;
                    rd_en_d      = ~req_write[winner_c];
                    wr_en_d      = req_write[winner_c];
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(0)) begin
                    rdata_d     = write_q ? DATA_W'(0) : mem_readdata;
                    rsp_valid_d = winner_q ? 2'b10 : 2'b01;
                    rd_en_d     = 1'b0;
                    wr_en_d     = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request, latency counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rdata_q      <= rdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
        end
    end

    // Address and write data hold their last captured values outside BUSY.
    assign mem_addr      = addr_q;
    assign mem_writedata = wdata_q;
    assign mem_read      = rd_en_q;
    assign mem_write     = wr_en_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-2 instance with a small write-back memory
// model and a latency-1 instance with a fixed address-derived memory.
module tb_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          LAT = 2;

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;

    logic [1:0]    valid, write, ready, rsp_valid;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rsp_rdata, mem_writedata, mem_readdata;
    logic          mem_read, mem_write;

    logic [1:0]    b_valid, b_write, b_ready, b_rsp_valid;
    logic [AW-1:0] b_addr0, b_addr1, b_mem_addr;
    logic [DW-1:0] b_wdata0, b_wdata1, b_rsp_rdata, b_mem_writedata, b_mem_readdata;
    logic          b_mem_read, b_mem_write;

    logic [DW-1:0] wmem [0:63];
    logic [63:0]   wvalid;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(valid), .req_write(write),
        .req_addr0(addr0), .req_addr1(addr1),
        .req_wdata0(wdata0), .req_wdata1(wdata1),
        .req_ready(ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_write(b_write),
        .req_addr0(b_addr0), .req_addr1(b_addr1),
        .req_wdata0(b_wdata0), .req_wdata1(b_wdata1),
        .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_writedata(b_mem_writedata),
        .mem_readdata(b_mem_readdata)
    );

    // Memory model: written words override an address-derived default.
    always_comb begin
        if (wvalid[mem_addr[7:2]] === 1'b1) mem_readdata = wmem[mem_addr[7:2]];
        else if (mem_addr == 32'h10)        mem_readdata = 32'hDEADBEEF;
        else                                mem_readdata = {mem_addr[15:0], ~mem_addr[15:0]};
    end

    always @(posedge clk) begin
        if (reset) begin
            wvalid <= '0;
        end else if (mem_write) begin
            wvalid[mem_addr[7:2]] <= 1'b1;
            wmem[mem_addr[7:2]]   <= mem_writedata;
        end
    end

    assign b_mem_readdata = b_mem_addr ^ 32'h5A5A_0000;

    function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
        if (wvalid[a[7:2]] === 1'b1) return wmem[a[7:2]];
        if (a == 32'h10)             return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic test_reset();
        valid = '0; write = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_valid = '0; b_write = '0; b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_writedata} !== '0)
            $display("FAIL reset_outputs: ready=%b rsp=%b rdata=%h rd=%b wr=%b addr=%h wd=%h, expected all 0",
                     ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_writedata);
        else passed++;
        checks++;
        if ({b_ready, b_rsp_valid, b_rsp_rdata, b_mem_read, b_mem_write, b_mem_addr, b_mem_writedata} !== '0)
            $display("FAIL reset_outputs_l1: ready=%b rsp=%b rd=%b wr=%b addr=%h, expected all 0",
                     b_ready, b_rsp_valid, b_mem_read, b_mem_write, b_mem_addr);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        exp_t e;
        @(negedge clk);
        valid = 2'b01; write = 2'b00; addr0 = 32'h10; #1;
        checks++;
        if (ready !== 2'b01) $display("FAIL read_ready: got %b expected 01", ready);
        else passed++;
        sb.push_back('{2'b01, 32'hDEADBEEF});
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            valid = 2'b00; #1;
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || ready !== 2'b00 || mem_addr !== 32'h10)
                $display("FAIL read_busy%0d: rd=%b wr=%b ready=%b addr=%h expected rd=1 wr=0 ready=00 addr=10",
                         k, mem_read, mem_write, ready, mem_addr);
            else passed++;
        end
        @(negedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== e.port || rsp_rdata !== e.data || mem_read !== 1'b0)
            $display("FAIL read_rsp: rsp=%b rdata=%h rd=%b expected rsp=%b rdata=%h rd=0",
                     rsp_valid, rsp_rdata, mem_read, e.port, e.data);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00) $display("FAIL read_rsp_pulse: rsp=%b expected 00", rsp_valid);
        else passed++;
    endtask

    task automatic test_write_hold();
        exp_t e;
        @(negedge clk);
        valid = 2'b10; write = 2'b10; addr1 = 32'h20; wdata1 = 32'h1234; #1;
        checks++;
        if (ready !== 2'b10) $display("FAIL write_ready: got %b expected 10", ready);
        else passed++;
        sb.push_back('{2'b10, 32'h0});
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            valid = 2'b00; write = 2'b00; addr1 = 32'hBAD0; wdata1 = 32'hBAD1; #1;
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h20 || mem_writedata !== 32'h1234)
                $display("FAIL write_busy%0d: wr=%b rd=%b addr=%h wd=%h expected wr=1 rd=0 addr=20 wd=1234",
                         k, mem_write, mem_read, mem_addr, mem_writedata);
            else passed++;
        end
        @(negedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== e.port || rsp_rdata !== e.data || mem_write !== 1'b0)
            $display("FAIL write_rsp: rsp=%b rdata=%h wr=%b expected rsp=%b rdata=%h wr=0",
                     rsp_valid, rsp_rdata, mem_write, e.port, e.data);
        else passed++;
        checks++;
        if (mem_addr !== 32'h20 || mem_writedata !== 32'h1234)
            $display("FAIL idle_bus_hold: addr=%h wd=%h expected 20/1234", mem_addr, mem_writedata);
        else passed++;
    endtask

    task automatic test_readback();
        exp_t e;
        bit   got = 0;
        @(negedge clk);
        valid = 2'b01; write = 2'b00; addr0 = 32'h20; #1;
        checks++;
        if (ready !== 2'b01) $display("FAIL readback_ready: got %b expected 01", ready);
        else passed++;
        sb.push_back('{2'b01, exp_mem(32'h20)});
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            valid = 2'b00; #1;
            if (rsp_valid !== 2'b00) begin
                got = 1;
                e = sb.pop_front();
                checks++;
                if (rsp_valid !== e.port || rsp_rdata !== e.data)
                    $display("FAIL readback_rsp: rsp=%b rdata=%h expected rsp=%b rdata=%h",
                             rsp_valid, rsp_rdata, e.port, e.data);
                else passed++;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL readback_timeout: no rsp_valid within 10 cycles, expected one");
            void'(sb.pop_front());
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   grants = 0;
        int   last_c = 0;
        bit   exp_port = 1'b0;
        bit   both_seen = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        valid = 2'b11; write = 2'b00; addr0 = 32'h40; addr1 = 32'h44;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (ready === 2'b11) both_seen = 1;
            if (ready !== 2'b00) begin
                checks++;
                if (ready !== (exp_port ? 2'b10 : 2'b01))
                    $display("FAIL rr_grant%0d: ready=%b expected %b", grants, ready, exp_port ? 2'b10 : 2'b01);
                else passed++;
                if (grants > 0) begin
                    checks++;
                    if (c - last_c != LAT + 2)
                        $display("FAIL rr_interval%0d: got %0d cycles expected %0d", grants, c - last_c, LAT + 2);
                    else passed++;
                end
                sb.push_back('{ready, exp_mem(ready[1] ? addr1 : addr0)});
                last_c = c;
                grants++;
                exp_port = ~exp_port;
            end
            if (rsp_valid !== 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rr_rsp_unexpected: rsp=%b with nothing outstanding", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== e.port || rsp_rdata !== e.data)
                        $display("FAIL rr_rsp: rsp=%b rdata=%h expected rsp=%b rdata=%h",
                                 rsp_valid, rsp_rdata, e.port, e.data);
                    else passed++;
                end
            end
            if (grants >= 4 && sb.size() == 0) break;
            @(negedge clk);
            if (grants >= 4) valid = 2'b00;
        end
        checks++;
        if (grants != 4 || sb.size() != 0 || both_seen)
            $display("FAIL rr_summary: grants=%0d outstanding=%0d ready11=%0d expected 4/0/0",
                     grants, sb.size(), both_seen);
        else passed++;
        sb.delete();
        valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got = 0;
        bit   leak = 0;
        // Port 0 is granted so that, without reset, the next tie would go to port 1.
        @(negedge clk);
        valid = 2'b01; write = 2'b00; addr0 = 32'h10; #1;
        checks++;
        if (ready !== 2'b01) $display("FAIL rst_mid_ready: got %b expected 01", ready);
        else passed++;
        @(negedge clk);
        valid = 2'b00;
        @(negedge clk);
        reset = 1'b1; #1;
        checks++;
        if (mem_read !== 1'b1) $display("FAIL rst_mid_busy2: rd=%b expected 1", mem_read);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if ({ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_writedata} !== '0)
            $display("FAIL rst_mid_outputs: rsp=%b rdata=%h rd=%b wr=%b addr=%h, expected all 0",
                     rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr);
        else passed++;
        reset = 1'b0;
        valid = 2'b11; addr0 = 32'h50; addr1 = 32'h54; #1;
        checks++;
        if (ready !== 2'b01) $display("FAIL rst_mid_tie: ready=%b expected 01", ready);
        else passed++;
        sb.push_back('{2'b01, exp_mem(32'h50)});
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            valid = 2'b00; #1;
            if (rsp_valid !== 2'b00) begin
                got = 1;
                e = sb.pop_front();
                checks++;
                if (rsp_valid !== e.port || rsp_rdata !== e.data)
                    $display("FAIL rst_mid_rsp: rsp=%b rdata=%h expected rsp=%b rdata=%h",
                             rsp_valid, rsp_rdata, e.port, e.data);
                else passed++;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL rst_mid_timeout: no rsp_valid within 10 cycles, expected one");
            void'(sb.pop_front());
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 2'b00) leak = 1;
        end
        checks++;
        if (leak) $display("FAIL rst_mid_leak: extra rsp_valid seen, expected none");
        else passed++;
    endtask

    task automatic test_latency1();
        @(negedge clk);
        b_valid = 2'b10; b_write = 2'b00; b_addr1 = 32'h8; #1;
        checks++;
        if (b_ready !== 2'b10) $display("FAIL l1_ready: got %b expected 10", b_ready);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (b_mem_read !== 1'b1 || b_mem_addr !== 32'h8 || b_ready !== 2'b00 || b_rsp_valid !== 2'b00)
            $display("FAIL l1_busy: rd=%b addr=%h ready=%b rsp=%b expected 1/8/00/00",
                     b_mem_read, b_mem_addr, b_ready, b_rsp_valid);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (b_mem_read !== 1'b0 || b_rsp_valid !== 2'b10 || b_rsp_rdata !== 32'h5A5A_0008 || b_ready !== 2'b00)
            $display("FAIL l1_rsp: rd=%b rsp=%b rdata=%h ready=%b expected 0/10/5a5a0008/00",
                     b_mem_read, b_rsp_valid, b_rsp_rdata, b_ready);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (b_ready !== 2'b10) $display("FAIL l1_next_accept: ready=%b expected 10", b_ready);
        else passed++;
        @(negedge clk);
        b_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_hold();
        test_readback();
        test_round_robin();
        test_reset_mid();
        test_latency1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
